// File: rtl/temporal_encoder.sv
// Turns a binary operand into a unary-in-time pulse stream over a fixed window of
// 2**DATA_WIDTH cycles. The ones come first, and there are in_data of them.
module temporal_encoder #(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  window_start,
  output logic                  window_done
);

  localparam logic [DATA_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  bit_out_d, bit_valid_d, window_start_d, window_done_d;
  logic                  accept;

  // cnt_q always indexes the beat that the output registers currently show. The
  // outputs are therefore loaded from the next-state values, which keeps accept
  // latency at one cycle.
  always_comb begin
    in_ready = !abort && ((state_q == IDLE) || (cnt_q == CNT_LAST));
    accept   = in_valid && in_ready;

    state_d  = state_q;
    cnt_d    = cnt_q;
    value_d  = value_q;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      value_d = in_data;
    end else if (state_q == RUN) begin
      if (cnt_q == CNT_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + DATA_WIDTH'(1);
      end
    end

    bit_valid_d    = (state_d == RUN);
    bit_out_d      = (state_d == RUN) && (cnt_d < value_d);
    window_start_d = (state_d == RUN) && (cnt_d == '0);
    window_done_d  = (state_d == RUN) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      value_q      <= '0;
      bit_out      <= 1'b0;
      bit_valid    <= 1'b0;
      window_start <= 1'b0;
      window_done  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      value_q      <= value_d;
      bit_out      <= bit_out_d;
      bit_valid    <= bit_valid_d;
      window_start <= window_start_d;
      window_done  <= window_done_d;
    end
  end

endmodule
